csc_encode_scheduler: RTL and testbench



---
 rtl/csc_encode_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_csc_encode_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csc_encode_scheduler.sv
// CSC encode scheduler: walks a batch of activation vectors in the iact
// feature buffer, streams each vector column-major into the CSC encoder
// through a 2-entry skid FIFO, waits for the encoder's vector-done, pulses
// the iact SRAM clear and moves on to the next vector.
module csc_encode_scheduler #(
  parameter int BUF_ADDR_WIDTH = 12,
  parameter int VEC_CNT_WIDTH  = 6,
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BUF_ADDR_WIDTH-1:0] base_addr,
  input  logic [VEC_CNT_WIDTH-1:0]  num_vectors,
  input  logic [4:0]                matrix_height,
  input  logic [4:0]                matrix_width,
  output logic                      buf_rd_en,
  output logic [BUF_ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic signed [7:0]         buf_rd_data,
  output logic                      enc_data_valid,
  output logic signed [7:0]         enc_data,
  input  logic                      enc_data_ready,
  input  logic                      enc_vector_done,
  output logic                      clear_iact_sram,
  output logic                      busy,
  output logic                      done,
  output logic [VEC_CNT_WIDTH-1:0]  vector_index,
  output logic                      timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [VEC_CNT_WIDTH:0] VEC_ONE = 1;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    WAIT_DONE,
    CLEAR,
    NEXT,
    FINISH
  } state_t;

  state_t state;

  // Batch configuration captured at start
  logic [VEC_CNT_WIDTH-1:0]  cfg_num;
  logic [4:0]                cfg_height;
  logic [9:0]                elem_total;
  logic [BUF_ADDR_WIDTH-1:0] vec_base;

  // Per-vector read walk and pop progress
  logic [4:0]       row;
  logic [4:0]       col;
  logic [9:0]       rd_count;
  logic [9:0]       pop_count;
  logic [TMO_W-1:0] wait_count;
  logic [CLR_W-1:0] clear_count;

  // Output FIFO: read data lands here one cycle after the strobe
  logic signed [7:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_count;
  logic              inflight;

  logic       pop;
  logic       reads_left;
  logic [2:0] held;
  logic [2:0] room;
  logic       rd_issue;
  logic [9:0] elem_offset;

  assign enc_data_valid = (fifo_count != 2'd0);
  assign enc_data       = fifo_mem[rd_ptr];
  assign pop            = enc_data_valid & enc_data_ready;

  // A read may only be issued if its data is guaranteed a FIFO slot,
  // counting entries already held, the read in flight and this cycle's pop.
  assign reads_left  = (rd_count != elem_total);
  assign held        = {1'b0, fifo_count} + {2'b00, inflight};
  assign room        = 3'd2 + {2'b00, pop};
  assign rd_issue    = (state == STREAM) && reads_left && (held < room);
  assign elem_offset = ({5'd0, col} * {5'd0, cfg_height}) + {5'd0, row};

  assign buf_rd_en   = rd_issue;
  assign buf_rd_addr = rd_issue ? (vec_base + BUF_ADDR_WIDTH'(elem_offset)) : '0;

  // Skid FIFO and read-return tracking; a reset discards any read in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      inflight <= rd_issue;
      if (inflight) begin
        fifo_mem[wr_ptr] <= buf_rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // Batch sequencing FSM with registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      cfg_num         <= '0;
      cfg_height      <= '0;
      elem_total      <= '0;
      vec_base        <= '0;
      row             <= '0;
      col             <= '0;
      rd_count        <= '0;
      pop_count       <= '0;
      wait_count      <= '0;
      clear_count     <= '0;
      clear_iact_sram <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      vector_index    <= '0;
      timeout_err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle is already IDLE; a start there must still be ignored
          if (start && !done) begin
            timeout_err  <= 1'b0;
            vector_index <= '0;
            cfg_num      <= num_vectors;
            cfg_height   <= matrix_height;
            elem_total   <= {5'd0, matrix_height} * {5'd0, matrix_width};
            vec_base     <= base_addr;
            row          <= '0;
            col          <= '0;
            rd_count     <= '0;
            pop_count    <= '0;
            if (num_vectors == '0) begin
              state <= FINISH;
            end else begin
              busy  <= 1'b1;
              state <= STREAM;
            end
          end
        end

        STREAM: begin
          if (rd_issue) begin
            rd_count <= rd_count + 10'd1;
            if (row == cfg_height - 5'd1) begin
              row <= '0;
              col <= col + 5'd1;
            end else begin
              row <= row + 5'd1;
            end
          end
          if (pop) begin
            pop_count <= pop_count + 10'd1;
            if (pop_count == elem_total - 10'd1) begin
              wait_count <= '0;
              state      <= WAIT_DONE;
            end
          end
        end

        WAIT_DONE: begin
          if (enc_vector_done) begin
            clear_iact_sram <= 1'b1;
            clear_count     <= '0;
            state           <= CLEAR;
          end else begin
            wait_count <= wait_count + TMO_W'(1);
            if (wait_count == TMO_W'(TIMEOUT_CYCLES - 1)) begin
              timeout_err     <= 1'b1;
              clear_iact_sram <= 1'b1;
              clear_count     <= '0;
              state           <= CLEAR;
            end
          end
        end

        CLEAR: begin
          // The encoder may report done while clearing; that is ignored here
          clear_count <= clear_count + CLR_W'(1);
          if (clear_count == CLR_W'(CLEAR_CYCLES - 1)) begin
            clear_iact_sram <= 1'b0;
            state           <= NEXT;
          end
        end

        NEXT: begin
          if ({1'b0, vector_index} + VEC_ONE == {1'b0, cfg_num}) begin
            state <= FINISH;
          end else begin
            vector_index <= vector_index + VEC_CNT_WIDTH'(1);
            vec_base     <= vec_base + BUF_ADDR_WIDTH'(elem_total);
            row          <= '0;
            col          <= '0;
            rd_count     <= '0;
            pop_count    <= '0;
            state        <= STREAM;
          end
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csc_encode_scheduler.sv
// Bench for csc_encode_scheduler: random buffer contents and handshake
// behaviour, checked against a flat address/data model of each batch.
module tb_csc_encode_scheduler;

  localparam int CLEAR_CYCLES   = 2;
  localparam int TIMEOUT_CYCLES = 64;

  logic              clock;
  logic              reset;
  logic              start;
  logic [11:0]       base_addr;
  logic [5:0]        num_vectors;
  logic [4:0]        matrix_height;
  logic [4:0]        matrix_width;
  logic              buf_rd_en;
  logic [11:0]       buf_rd_addr;
  logic signed [7:0] buf_rd_data;
  logic              enc_data_valid;
  logic signed [7:0] enc_data;
  logic              enc_data_ready;
  logic              enc_vector_done;
  logic              clear_iact_sram;
  logic              busy;
  logic              done;
  logic [5:0]        vector_index;
  logic              timeout_err;

  csc_encode_scheduler #(
    .BUF_ADDR_WIDTH(12),
    .VEC_CNT_WIDTH (6),
    .CLEAR_CYCLES  (CLEAR_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .num_vectors    (num_vectors),
    .matrix_height  (matrix_height),
    .matrix_width   (matrix_width),
    .buf_rd_en      (buf_rd_en),
    .buf_rd_addr    (buf_rd_addr),
    .buf_rd_data    (buf_rd_data),
    .enc_data_valid (enc_data_valid),
    .enc_data       (enc_data),
    .enc_data_ready (enc_data_ready),
    .enc_vector_done(enc_vector_done),
    .clear_iact_sram(clear_iact_sram),
    .busy           (busy),
    .done           (done),
    .vector_index   (vector_index),
    .timeout_err    (timeout_err)
  );

  logic [31:0] outs;
  assign outs = {buf_rd_en, buf_rd_addr, enc_data_valid, enc_data, clear_iact_sram,
                 busy, done, vector_index, timeout_err};

  logic [7:0] mem [4096];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Written by the main sequence
  int ready_mode = 0;
  int done_delay = 0;
  int cur_hw     = 1;
  bit clr_req    = 1'b0;
  int batch_start_cyc;
  int last_done_cyc;

  // Written by the monitor
  bit          clr_ack = 1'b0;
  int unsigned rd_addr_q[$];
  int unsigned rd_vidx_q[$];
  logic [7:0]  pop_q[$];
  int          vend_q[$];
  int done_at = -1;
  int to_cyc = -1;
  int clear_cyc, bursts, burst_err, run_len, done_cnt, stall_err, occ_err, busy_err, vpops;
  int first_rd_cyc = -1;
  int last_rd_cyc = -1;
  int first_vld_cyc = -1;
  bit prev_stall;
  logic [7:0] prev_data;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Feature buffer: one-cycle read latency, junk on cycles without a read
  always @(posedge clock) begin
    buf_rd_data <= buf_rd_en ? mem[buf_rd_addr] : 8'($urandom);
  end

  // Encoder side: ready pattern and a 3-cycle vector-done after a delay
  initial begin
    enc_data_ready  = 1'b0;
    enc_vector_done = 1'b0;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      case (ready_mode)
        0:       enc_data_ready = 1'b1;
        1:       enc_data_ready = ~enc_data_ready;
        default: enc_data_ready = 1'($urandom_range(0, 1));
      endcase
      enc_vector_done = (done_at >= 0) && (cyc >= done_at) && (cyc < done_at + 3);
    end
  end

  // Monitor: records reads, pops, clear bursts and protocol violations
  initial begin
    forever begin
      @(negedge clock);
      if (clr_req != clr_ack) begin
        clr_ack = clr_req;
        rd_addr_q.delete(); rd_vidx_q.delete(); pop_q.delete(); vend_q.delete();
        done_at = -1; to_cyc = -1; clear_cyc = 0; bursts = 0; burst_err = 0; run_len = 0;
        done_cnt = 0; stall_err = 0; occ_err = 0; busy_err = 0; vpops = 0;
        first_rd_cyc = -1; last_rd_cyc = -1; first_vld_cyc = -1; prev_stall = 1'b0;
      end
      if (buf_rd_en) begin
        rd_addr_q.push_back(int'(buf_rd_addr));
        rd_vidx_q.push_back(int'(vector_index));
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        if (!busy) busy_err++;
      end
      if (enc_data_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (prev_stall && (!enc_data_valid || enc_data != prev_data)) stall_err++;
      prev_stall = enc_data_valid && !enc_data_ready;
      prev_data  = enc_data;
      if (enc_data_valid && enc_data_ready) begin
        pop_q.push_back(enc_data);
        vpops++;
        if (vpops == cur_hw) begin
          vpops = 0;
          vend_q.push_back(cyc);
          if (done_delay >= 0) done_at = cyc + done_delay;
        end
      end
      if (int'(rd_addr_q.size()) - int'(pop_q.size()) > 2) occ_err++;
      if (clear_iact_sram) begin
        clear_cyc++;
        run_len++;
      end else if (run_len > 0) begin
        if (run_len != CLEAR_CYCLES) burst_err++;
        bursts++;
        run_len = 0;
      end
      if (done) done_cnt++;
      if (timeout_err && to_cyc < 0) to_cyc = cyc;
    end
  end

  task automatic run_batch(input string tag, input int h, input int w, input int n,
                           input int base, input int rmode, input int ddelay, input bit poke);
    int hw;
    int am;
    int dm;
    int vm;
    int ea;
    bit got;
    hw = h * w;
    @(posedge clock); #1;
    ready_mode    = rmode;
    done_delay    = ddelay;
    cur_hw        = hw;
    clr_req       = ~clr_req;
    matrix_height = 5'(h);
    matrix_width  = 5'(w);
    num_vectors   = 6'(n);
    base_addr     = 12'(base);
    start         = 1'b1;
    batch_start_cyc = cyc;
    @(posedge clock); #1;
    start         = 1'b0;
    base_addr     = 12'($urandom);
    num_vectors   = 6'($urandom_range(1, 63));
    matrix_height = 5'($urandom_range(1, 31));
    matrix_width  = 5'($urandom_range(1, 31));
    got = 1'b0;
    last_done_cyc = -1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clock);
      if (k == 0) begin
        check_eq({tag, "_busy_at_start"}, busy, (n != 0));
        check_eq({tag, "_tmo_cleared"}, timeout_err, 0);
      end
      if (poke && k == 4) start = 1'b1;
      if (poke && k == 5) start = 1'b0;
      if (done) begin
        got = 1'b1;
        last_done_cyc = cyc;
        break;
      end
    end
    check_eq({tag, "_done_seen"}, got, 1);
    if (poke) begin
      start       = 1'b1;
      num_vectors = 6'd1;
      @(negedge clock);
      start = 1'b0;
      #1;
      check_eq({tag, "_start_on_done_ignored"}, busy, 0);
    end
    @(negedge clock); #1;
    am = 0; dm = 0; vm = 0;
    for (int i = 0; i < rd_addr_q.size(); i++) begin
      ea = (base + i) % 4096;
      if (rd_addr_q[i] != ea) am++;
      if (rd_vidx_q[i] != i / hw) vm++;
    end
    for (int i = 0; i < pop_q.size(); i++) begin
      ea = (base + i) % 4096;
      if (pop_q[i] != mem[ea]) dm++;
    end
    $display("batch %s: h=%0d w=%0d n=%0d base=%03h reads=%0d pops=%0d", tag, h, w, n,
             base, rd_addr_q.size(), pop_q.size());
    check_eq({tag, "_reads"}, rd_addr_q.size(), n * hw);
    check_eq({tag, "_pops"}, pop_q.size(), n * hw);
    check_eq({tag, "_addr_errs"}, am, 0);
    check_eq({tag, "_data_errs"}, dm, 0);
    check_eq({tag, "_vidx_errs"}, vm, 0);
    check_eq({tag, "_clear_cycles"}, clear_cyc, n * CLEAR_CYCLES);
    check_eq({tag, "_clear_bursts"}, bursts, n);
    check_eq({tag, "_burst_len_errs"}, burst_err, 0);
    check_eq({tag, "_done_pulses"}, done_cnt, 1);
    check_eq({tag, "_stall_errs"}, stall_err, 0);
    check_eq({tag, "_fifo_overflow"}, occ_err, 0);
    check_eq({tag, "_read_while_idle"}, busy_err, 0);
    check_eq({tag, "_busy_after"}, busy, 0);
    if (n > 0) check_eq({tag, "_final_vidx"}, vector_index, n - 1);
  endtask

  initial begin
    bit got;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    reset         = 1'b1;
    start         = 1'b0;
    base_addr     = '0;
    num_vectors   = '0;
    matrix_height = 5'd1;
    matrix_width  = 5'd1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("reset_outputs", outs, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    run_batch("single", 4, 3, 1, 'h010, 0, 3, 1'b0);
    check_eq("single_first_read_lat", first_rd_cyc - batch_start_cyc, 1);
    check_eq("single_first_valid_lat", first_vld_cyc - batch_start_cyc, 3);
    check_eq("single_read_span", last_rd_cyc - first_rd_cyc, 11);

    run_batch("toggle", 4, 3, 1, 'h010, 1, 3, 1'b0);
    run_batch("multi", 2, 2, 3, 'h100, 0, 2, 1'b0);

    run_batch("timeout", 2, 3, 1, 'h200, 0, -1, 1'b0);
    check_eq("timeout_flag", timeout_err, 1);
    check_eq("timeout_latency", (vend_q.size() > 0) ? (to_cyc - vend_q[0]) : -1,
             TIMEOUT_CYCLES + 1);
    run_batch("after_timeout", 3, 2, 1, int'($urandom_range(0, 4095)), 2, 2, 1'b0);

    run_batch("zero_vec", 3, 3, 0, 'h050, 0, 2, 1'b0);
    check_eq("zero_vec_done_lat", last_done_cyc - batch_start_cyc, 2);

    // Abort a batch with reset after a few pops
    @(posedge clock); #1;
    ready_mode    = 0;
    done_delay    = 2;
    cur_hw        = 16;
    clr_req       = ~clr_req;
    matrix_height = 5'd4;
    matrix_width  = 5'd4;
    num_vectors   = 6'd2;
    base_addr     = 12'h300;
    start         = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock); #1;
      if (pop_q.size() >= 5) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("abort_pops_reached", got, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_eq("abort_outputs_zero", outs, 0);

    run_batch("after_reset", 1, 1, 1, 'h3A5, 0, 1, 1'b0);
    run_batch("max_wrap", 31, 31, 1, 'hFC0, 0, 2, 1'b0);

    for (int r = 0; r < 4; r++) begin
      run_batch($sformatf("rand%0d", r), int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                int'($urandom_range(1, 3)), int'($urandom_range(0, 4095)), 2,
                int'($urandom_range(1, 4)), (r == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
